// File: rtl/hdc_pkg.sv
// Shared types and defaults for the HDC classification sequencer.
package hdc_pkg;

  localparam int unsigned DRAIN_CYC_DEF   = 8;
  localparam int unsigned TIMEOUT_CYC_DEF = 4096;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    FETCH    = 3'd1,
    WAIT_MEM = 3'd2,
    RUN      = 3'd3,
    DRAIN    = 3'd4,
    RESULT   = 3'd5
  } seq_state_t;

  // Class index width; a single class still needs one bit.
  function automatic int unsigned cls_w(input int unsigned num_c);
    return (num_c > 32'd1) ? 32'($clog2(num_c)) : 32'd1;
  endfunction

endpackage

// File: rtl/hdc_seq_watchdog.sv
// Clear/enable up-counter that saturates at LIMIT-1 and flags its terminal count.
module hdc_seq_watchdog #(
  parameter int unsigned LIMIT = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic tc_c
);

  localparam int unsigned CNT_W = (LIMIT > 1) ? $clog2(LIMIT) : 1;

  logic [CNT_W-1:0] cnt;

  assign tc_c = (cnt == CNT_W'(LIMIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en && !tc_c) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/hdc_class_sequencer.sv
// Sequences one HDC query through the dot-product/argmax datapath, one class
// hypervector at a time, and returns the predicted label (or a watchdog abort).
module hdc_class_sequencer
  import hdc_pkg::*;
#(
  parameter int unsigned D           = 8192,
  parameter int unsigned NUM_C       = 10,
  parameter int unsigned CLS_W       = cls_w(NUM_C),
  parameter int unsigned DRAIN_CYC   = DRAIN_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             q_valid,
  output logic             q_ready,
  input  logic [D-1:0]     q_hv,
  output logic             mem_rd_en,
  output logic [CLS_W-1:0] mem_rd_addr,
  input  logic             mem_rvalid,
  input  logic [D-1:0]     mem_rdata,
  output logic             dp_start,
  output logic [CLS_W-1:0] dp_class_L,
  output logic [D-1:0]     dp_in_hv,
  output logic [D-1:0]     dp_class_hv,
  input  logic             dp_next_class,
  input  logic [CLS_W-1:0] dp_pred_label,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [CLS_W-1:0] res_label,
  output logic             res_err,
  output logic             busy
);

  seq_state_t       state, state_d;
  logic [CLS_W-1:0] cls_cnt, cls_cnt_d;
  logic [D-1:0]     hv_q, class_q;

  logic accept_c;
  logic class_load_c;
  logic label_load_c;
  logic wd_fire_c;
  logic wd_tc_c;
  logic drain_tc_c;
  logic state_chg_c;

  // State and class counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cls_cnt <= '0;
    end else begin
      state   <= state_d;
      cls_cnt <= cls_cnt_d;
    end
  end

  // Next-state logic; a completed read or class beats a coincident watchdog expiry.
  always_comb begin
    state_d      = state;
    cls_cnt_d    = cls_cnt;
    accept_c     = 1'b0;
    class_load_c = 1'b0;
    label_load_c = 1'b0;
    wd_fire_c    = 1'b0;
    case (state)
      IDLE: begin
        if (q_valid && q_ready) begin
          accept_c  = 1'b1;
          cls_cnt_d = '0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        state_d = WAIT_MEM;
      end
      WAIT_MEM: begin
        if (mem_rvalid) begin
          class_load_c = 1'b1;
          state_d      = RUN;
        end else if (wd_tc_c) begin
          wd_fire_c = 1'b1;
          state_d   = RESULT;
        end
      end
      RUN: begin
        if (dp_next_class) begin
          if (cls_cnt == CLS_W'(NUM_C - 1)) begin
            state_d = DRAIN;
          end else begin
            cls_cnt_d = cls_cnt + CLS_W'(1);
            state_d   = FETCH;
          end
        end else if (wd_tc_c) begin
          wd_fire_c = 1'b1;
          state_d   = RESULT;
        end
      end
      DRAIN: begin
        if (drain_tc_c) begin
          label_load_c = 1'b1;
          state_d      = RESULT;
        end
      end
      RESULT: begin
        if (res_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign state_chg_c = (state_d != state);

  hdc_seq_watchdog #(
    .LIMIT (TIMEOUT_CYC)
  ) u_watchdog (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg_c),
    .en    ((state == WAIT_MEM) || (state == RUN)),
    .tc_c  (wd_tc_c)
  );

  hdc_seq_watchdog #(
    .LIMIT (DRAIN_CYC)
  ) u_drain (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (state_chg_c),
    .en    (state == DRAIN),
    .tc_c  (drain_tc_c)
  );

  // Control outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q_ready     <= 1'b0;
      busy        <= 1'b0;
      mem_rd_en   <= 1'b0;
      mem_rd_addr <= '0;
      dp_start    <= 1'b0;
      dp_class_L  <= '0;
      res_valid   <= 1'b0;
    end else begin
      q_ready     <= (state_d == IDLE);
      busy        <= (state_d != IDLE);
      mem_rd_en   <= (state_d == FETCH);
      mem_rd_addr <= cls_cnt_d;
      dp_start    <= (state_d == RUN);
      dp_class_L  <= cls_cnt_d;
      res_valid   <= (state_d == RESULT);
    end
  end

  // Hypervector holding registers and result payload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hv_q      <= '0;
      class_q   <= '0;
      res_label <= '0;
      res_err   <= 1'b0;
    end else begin
      if (accept_c) begin
        hv_q    <= q_hv;
        res_err <= 1'b0;
      end
      if (class_load_c) begin
        class_q <= mem_rdata;
      end
      if (label_load_c) begin
        res_label <= dp_pred_label;
      end else if (wd_fire_c) begin
        res_label <= '0;
        res_err   <= 1'b1;
      end
    end
  end

  assign dp_in_hv    = hv_q;
  assign dp_class_hv = class_q;

endmodule

// File: tb/tb_hdc_class_sequencer.sv
// Scoreboard bench for hdc_class_sequencer with class-memory and datapath models.
`timescale 1ns/1ps
module tb_hdc_class_sequencer;

  localparam int unsigned D           = 64;
  localparam int unsigned NUM_C       = 10;
  localparam int unsigned CLS_W       = 4;
  localparam int unsigned DRAIN_CYC   = 8;
  localparam int unsigned TIMEOUT_CYC = 64;

  typedef struct packed {
    logic [CLS_W-1:0] label;
    logic             err;
  } res_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             q_valid = 1'b0;
  logic             q_ready;
  logic [D-1:0]     q_hv = '0;
  logic             mem_rd_en;
  logic [CLS_W-1:0] mem_rd_addr;
  logic             mem_rvalid;
  logic [D-1:0]     mem_rdata;
  logic             dp_start;
  logic [CLS_W-1:0] dp_class_L;
  logic [D-1:0]     dp_in_hv;
  logic [D-1:0]     dp_class_hv;
  logic             dp_next_class;
  logic [CLS_W-1:0] dp_pred_label = '0;
  logic             res_valid;
  logic             res_ready = 1'b0;
  logic [CLS_W-1:0] res_label;
  logic             res_err;
  logic             busy;

  int vec_cnt = 0;
  int err_cnt = 0;
  int cyc = 0;

  int mem_mode = 0;
  int dp_dly = 5;
  logic [D-1:0] cur_q_hv = '0;
  logic [CLS_W-1:0] exp_addr_q[$];
  res_t exp_res_q[$];

  int pulse_cnt = 0;
  int last_pulse_cyc = 0;
  int last_rd_cyc = 0;
  logic [CLS_W-1:0] last_rd_addr = '0;
  logic dp_start_d = 1'b0;

  hdc_class_sequencer #(
    .D           (D),
    .NUM_C       (NUM_C),
    .CLS_W       (CLS_W),
    .DRAIN_CYC   (DRAIN_CYC),
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .q_valid       (q_valid),
    .q_ready       (q_ready),
    .q_hv          (q_hv),
    .mem_rd_en     (mem_rd_en),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rvalid    (mem_rvalid),
    .mem_rdata     (mem_rdata),
    .dp_start      (dp_start),
    .dp_class_L    (dp_class_L),
    .dp_in_hv      (dp_in_hv),
    .dp_class_hv   (dp_class_hv),
    .dp_next_class (dp_next_class),
    .dp_pred_label (dp_pred_label),
    .res_valid     (res_valid),
    .res_ready     (res_ready),
    .res_label     (res_label),
    .res_err       (res_err),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [D-1:0] pat(input int idx);
    logic [D-1:0] v;
    v = '0;
    for (int k = 0; k < int'(D / 32); k++) begin
      v[k*32 +: 32] = 32'hC1A5_0000 ^ 32'(idx << 8) ^ 32'(k);
    end
    return v;
  endfunction

  function automatic logic [D-1:0] rand_hv();
    logic [D-1:0] v;
    v = '0;
    for (int k = 0; k < int'(D / 32); k++) begin
      v[k*32 +: 32] = $urandom();
    end
    return v;
  endfunction

  // Class memory: latency 1 (mode 0), random 1..6 (mode 1), class 3 never answers (mode 2).
  int mem_rem;
  int next_lat;
  logic [CLS_W-1:0] mem_addr;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_rvalid <= 1'b0;
      mem_rdata  <= '0;
      mem_rem    <= 0;
      next_lat   <= 1;
      mem_addr   <= '0;
    end else begin
      mem_rvalid <= 1'b0;
      if (mem_rd_en && !(mem_mode == 2 && mem_rd_addr == CLS_W'(3))) begin
        mem_addr <= mem_rd_addr;
        mem_rem  <= next_lat - 1;
        if (next_lat == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= pat(int'(mem_rd_addr));
        end
        next_lat <= (mem_mode == 1) ? int'($urandom_range(6, 1)) : 1;
      end else if (mem_rem > 0) begin
        mem_rem <= mem_rem - 1;
        if (mem_rem == 1) begin
          mem_rvalid <= 1'b1;
          mem_rdata  <= pat(int'(mem_addr));
        end
      end
    end
  end

  // Datapath: pulses dp_next_class dp_dly cycles into each run.
  int run_cnt;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt       <= 0;
      dp_next_class <= 1'b0;
    end else if (!dp_start) begin
      run_cnt       <= 0;
      dp_next_class <= 1'b0;
    end else begin
      run_cnt       <= run_cnt + 1;
      dp_next_class <= (run_cnt == dp_dly - 1);
    end
  end

  // Monitor: read order, dp_start gating and class payload on every run start.
  initial begin
    logic [CLS_W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (mem_rd_en) begin
          vec_cnt++;
          last_rd_cyc  = cyc;
          last_rd_addr = mem_rd_addr;
          if (exp_addr_q.size() == 0) begin
            err_cnt++;
            $display("FAIL rd_addr: got unexpected read addr=%0d, wanted no read", mem_rd_addr);
          end else begin
            e = exp_addr_q.pop_front();
            if (mem_rd_addr !== e || dp_start !== 1'b0) begin
              err_cnt++;
              $display("FAIL rd_addr: got addr=%0d dp_start=%b, wanted addr=%0d dp_start=0",
                       mem_rd_addr, dp_start, e);
            end
          end
        end
        if (mem_rem > 0 || mem_rvalid) begin
          vec_cnt++;
          if (dp_start !== 1'b0) begin
            err_cnt++;
            $display("FAIL dp_start_wait_mem: got %b, wanted 0", dp_start);
          end
        end
        if (dp_start && !dp_start_d) begin
          vec_cnt++;
          if (dp_class_hv !== pat(int'(last_rd_addr)) || dp_class_L !== last_rd_addr ||
              dp_in_hv !== cur_q_hv) begin
            err_cnt++;
            $display("FAIL run_payload: got cls=%0d class_hv=%h in_hv=%h, wanted cls=%0d class_hv=%h in_hv=%h",
                     dp_class_L, dp_class_hv, dp_in_hv, last_rd_addr, pat(int'(last_rd_addr)), cur_q_hv);
          end
        end
        if (dp_start && dp_next_class) begin
          pulse_cnt++;
          last_pulse_cyc = cyc;
        end
      end
      dp_start_d = dp_start;
    end
  end

  initial begin
    #300us;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "global timeout");
  end

  task automatic drive_query(input logic [D-1:0] hv, input int n_cls,
                             input logic [CLS_W-1:0] lbl, input logic err);
    res_t r;
    for (int i = 0; i < n_cls; i++) exp_addr_q.push_back(CLS_W'(i));
    r.label = lbl;
    r.err   = err;
    exp_res_q.push_back(r);
    @(negedge clk);
    q_valid  = 1'b1;
    q_hv     = hv;
    cur_q_hv = hv;
    for (int i = 0; i < 50 && !q_ready; i++) @(negedge clk);
    vec_cnt++;
    if (q_ready !== 1'b1) begin
      err_cnt++;
      $display("FAIL accept: got q_ready=%b, wanted 1", q_ready);
    end
    @(posedge clk);
    #1;
    q_valid = 1'b0;
  endtask

  task automatic wait_result(input int limit, output bit ok, output int rise_cyc);
    ok = 1'b0;
    rise_cyc = 0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (res_valid) begin
        ok = 1'b1;
        rise_cyc = cyc;
        break;
      end
    end
  endtask

  task automatic ack_result();
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vec_cnt++;
    if ({q_ready, mem_rd_en, mem_rd_addr, dp_start, dp_class_L, res_valid, res_label, res_err, busy} !== '0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got q_ready=%b rd_en=%b addr=%0d start=%b cls=%0d rv=%b lbl=%0d err=%b busy=%b, wanted all 0",
               q_ready, mem_rd_en, mem_rd_addr, dp_start, dp_class_L, res_valid, res_label, res_err, busy);
    end
    vec_cnt++;
    if (dp_in_hv !== '0 || dp_class_hv !== '0) begin
      err_cnt++;
      $display("FAIL reset_hv: got in_hv=%h class_hv=%h, wanted 0", dp_in_hv, dp_class_hv);
    end
    rst_n = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (q_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_release: got q_ready=%b busy=%b, wanted 1/0", q_ready, busy);
    end
  endtask

  task automatic test_nominal();
    bit ok;
    int rc;
    res_t e;
    mem_mode = 0;
    dp_dly = 5;
    dp_pred_label = CLS_W'(7);
    pulse_cnt = 0;
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    wait_result(2000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL nominal_result: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    vec_cnt++;
    if (rc - last_pulse_cyc != int'(DRAIN_CYC) + 1) begin
      err_cnt++;
      $display("FAIL nominal_drain: got %0d cycles after last pulse, wanted %0d", rc - last_pulse_cyc, DRAIN_CYC + 1);
    end
    vec_cnt++;
    if (pulse_cnt != int'(NUM_C) || exp_addr_q.size() != 0) begin
      err_cnt++;
      $display("FAIL nominal_classes: got pulses=%0d unread=%0d, wanted %0d/0", pulse_cnt, exp_addr_q.size(), NUM_C);
    end
    ack_result();
    vec_cnt++;
    if (res_valid !== 1'b0 || q_ready !== 1'b1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL nominal_release: got rv=%b q_ready=%b busy=%b, wanted 0/1/0", res_valid, q_ready, busy);
    end
  endtask

  task automatic test_mem_latency();
    bit ok;
    int rc;
    res_t e;
    mem_mode = 1;
    dp_dly = 5;
    dp_pred_label = CLS_W'(7);
    for (int q = 0; q < 2; q++) begin
      drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
      wait_result(3000, ok, rc);
      e = exp_res_q.pop_front();
      vec_cnt++;
      if (!ok || res_label !== e.label || res_err !== e.err || exp_addr_q.size() != 0) begin
        err_cnt++;
        $display("FAIL latency_result: got valid=%b label=%0d err=%b unread=%0d, wanted 1/%0d/%b/0",
                 ok, res_label, res_err, exp_addr_q.size(), e.label, e.err);
      end
      ack_result();
    end
    mem_mode = 0;
  endtask

  task automatic test_backpressure();
    bit ok;
    int rc;
    res_t e;
    logic [D-1:0] hv2;
    res_t r2;
    mem_mode = 0;
    dp_dly = 5;
    dp_pred_label = CLS_W'(7);
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    wait_result(2000, ok, rc);
    dp_pred_label = CLS_W'(2);
    hv2 = rand_hv();
    for (int i = 0; i < int'(NUM_C); i++) exp_addr_q.push_back(CLS_W'(i));
    r2.label = CLS_W'(2);
    r2.err   = 1'b0;
    q_valid = 1'b1;
    q_hv    = hv2;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      vec_cnt++;
      if (res_valid !== 1'b1 || res_label !== CLS_W'(7) || q_ready !== 1'b0 || mem_rd_en !== 1'b0) begin
        err_cnt++;
        $display("FAIL bp_hold[%0d]: got rv=%b label=%0d q_ready=%b rd_en=%b, wanted 1/7/0/0",
                 i, res_valid, res_label, q_ready, mem_rd_en);
      end
    end
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL bp_result: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    exp_res_q.push_back(r2);
    ack_result();
    cur_q_hv = hv2;
    vec_cnt++;
    if (q_ready !== 1'b1 || res_valid !== 1'b0 || mem_rd_en !== 1'b0) begin
      err_cnt++;
      $display("FAIL bp_idle: got q_ready=%b rv=%b rd_en=%b, wanted 1/0/0", q_ready, res_valid, mem_rd_en);
    end
    @(negedge clk);
    q_valid = 1'b0;
    vec_cnt++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== '0) begin
      err_cnt++;
      $display("FAIL bp_second_fetch: got rd_en=%b addr=%0d, wanted 1/0", mem_rd_en, mem_rd_addr);
    end
    wait_result(2000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL bp_second_result: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    ack_result();
    dp_pred_label = CLS_W'(7);
  endtask

  task automatic test_watchdog();
    bit ok;
    int rc;
    res_t e;
    mem_mode = 2;
    dp_dly = 5;
    dp_pred_label = CLS_W'(7);
    drive_query(rand_hv(), 4, '0, 1'b1);
    wait_result(2000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL wd_result: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    vec_cnt++;
    if (rc - last_rd_cyc != int'(TIMEOUT_CYC) + 1 || last_rd_addr !== CLS_W'(3)) begin
      err_cnt++;
      $display("FAIL wd_timing: got %0d cycles after read of %0d, wanted %0d after read of 3",
               rc - last_rd_cyc, last_rd_addr, TIMEOUT_CYC + 1);
    end
    ack_result();
    mem_mode = 0;
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    wait_result(2000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL wd_recover: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    ack_result();
  endtask

  task automatic test_coincidence();
    bit ok;
    int rc;
    res_t e;
    mem_mode = 0;
    dp_dly = int'(TIMEOUT_CYC) - 1;
    dp_pred_label = CLS_W'(7);
    pulse_cnt = 0;
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    wait_result(4000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err) begin
      err_cnt++;
      $display("FAIL coincide_result: got valid=%b label=%0d err=%b, wanted 1/%0d/%b", ok, res_label, res_err, e.label, e.err);
    end
    vec_cnt++;
    if (pulse_cnt != int'(NUM_C) || exp_addr_q.size() != 0) begin
      err_cnt++;
      $display("FAIL coincide_classes: got pulses=%0d unread=%0d, wanted %0d/0", pulse_cnt, exp_addr_q.size(), NUM_C);
    end
    ack_result();
    dp_dly = 5;
  endtask

  task automatic test_reset_mid_run();
    bit seen;
    bit ok;
    int rc;
    res_t e;
    seen = 1'b0;
    mem_mode = 0;
    dp_dly = 5;
    dp_pred_label = CLS_W'(7);
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    for (int i = 0; i < 500 && !seen; i++) begin
      @(negedge clk);
      if (dp_start && dp_class_L == CLS_W'(4)) seen = 1'b1;
    end
    vec_cnt++;
    if (!seen) begin
      err_cnt++;
      $display("FAIL mid_reach: got no RUN on class 4, wanted RUN with dp_class_L=4");
    end
    #2 rst_n = 1'b0;
    #1;
    vec_cnt++;
    if ({q_ready, mem_rd_en, mem_rd_addr, dp_start, dp_class_L, res_valid, res_label, res_err, busy} !== '0) begin
      err_cnt++;
      $display("FAIL mid_reset_ctrl: got q_ready=%b rd_en=%b addr=%0d start=%b cls=%0d rv=%b lbl=%0d err=%b busy=%b, wanted all 0",
               q_ready, mem_rd_en, mem_rd_addr, dp_start, dp_class_L, res_valid, res_label, res_err, busy);
    end
    vec_cnt++;
    if (dp_in_hv !== '0 || dp_class_hv !== '0) begin
      err_cnt++;
      $display("FAIL mid_reset_hv: got in_hv=%h class_hv=%h, wanted 0", dp_in_hv, dp_class_hv);
    end
    exp_addr_q.delete();
    exp_res_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive_query(rand_hv(), NUM_C, CLS_W'(7), 1'b0);
    @(negedge clk);
    vec_cnt++;
    if (mem_rd_en !== 1'b1 || mem_rd_addr !== '0) begin
      err_cnt++;
      $display("FAIL mid_restart: got rd_en=%b addr=%0d, wanted 1/0", mem_rd_en, mem_rd_addr);
    end
    wait_result(2000, ok, rc);
    e = exp_res_q.pop_front();
    vec_cnt++;
    if (!ok || res_label !== e.label || res_err !== e.err || exp_addr_q.size() != 0) begin
      err_cnt++;
      $display("FAIL mid_restart_result: got valid=%b label=%0d err=%b unread=%0d, wanted 1/%0d/%b/0",
               ok, res_label, res_err, exp_addr_q.size(), e.label, e.err);
    end
    ack_result();
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_mem_latency();
    test_backpressure();
    test_watchdog();
    test_coincidence();
    test_reset_mid_run();
    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
